epass_reader: RTL and testbench

EPASS_READER -- requirements
Module: epass_reader

---
 rtl/epass_pkg.sv | 33 +++
 rtl/epass_byte_rx.sv | 160 ++++++++++++++++
 rtl/epass_reader.sv | 151 +++++++++++++++
 tb/tb_epass_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epass_pkg.sv
`default_nettype none
// ============================================================================
// Module : epass_pkg
// Brief  : Shared constants and state encodings for the E-pass tag reader.
//          The receiver parity state exists only when EPASS_PARITY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
package epass_pkg;

    localparam logic [7:0] EPASS_SOF         = 8'hA5;
    localparam int         EPASS_FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3
`ifdef EPASS_PARITY_EN
        ,
        RX_PAR   = 3'd4
`endif
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/epass_byte_rx.sv
`default_nettype none
// ============================================================================
// Module : epass_byte_rx
// Brief  : rx synchronizer, bit timing and shifter; emits one-cycle byte strobes.
//          EPASS_PARITY_EN adds an even-parity bit between D7 and stop.
// Rev    : 1.0  initial release
// ============================================================================
module epass_byte_rx
    import epass_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    input  logic       flush_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_err_o
);

    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int HALF = CLK_PER_BIT / 2;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bits_q, bits_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      byte_q, byte_d;
    logic            bv_q, bv_d;
    logic            be_q, be_d;
    logic            w_tick;
    logic            w_par_ok;

`ifdef EPASS_PARITY_EN
    logic            par_q, par_d;
    assign w_par_ok = ~(^{par_q, sh_q});
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_tick = (cnt_q == CW'(CLK_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            st_q      <= RX_IDLE;
            cnt_q     <= '0;
            bits_q    <= '0;
            sh_q      <= '0;
            byte_q    <= '0;
            bv_q      <= 1'b0;
            be_q      <= 1'b0;
`ifdef EPASS_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            sh_q      <= sh_d;
            byte_q    <= byte_d;
            bv_q      <= bv_d;
            be_q      <= be_d;
`ifdef EPASS_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        bits_d = bits_q;
        sh_d   = sh_q;
        byte_d = byte_q;
        bv_d   = 1'b0;
        be_d   = 1'b0;
`ifdef EPASS_PARITY_EN
        par_d  = par_q;
`endif
        case (st_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                // A start bit that has gone high again by its midpoint is a glitch.
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d  = '0;
                    bits_d = '0;
                    st_d   = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    cnt_d  = '0;
                    sh_d   = {rx_s2_q, sh_q[7:1]};
                    bits_d = bits_q + 1'b1;
                    if (bits_q == 3'd7) begin
`ifdef EPASS_PARITY_EN
                        st_d = RX_PAR;
`else
                        st_d = RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef EPASS_PARITY_EN
            RX_PAR: begin
                if (w_tick) begin
                    cnt_d = '0;
                    par_d = rx_s2_q;
                    st_d  = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (w_tick) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (rx_s2_q && w_par_ok) begin
                        bv_d   = 1'b1;
                        byte_d = sh_q;
                    end else begin
                        be_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
        if (flush_i) begin
            st_d   = RX_IDLE;
            cnt_d  = '0;
            bits_d = '0;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = bv_q;
    assign byte_err_o   = be_q;

endmodule
`default_nettype wire

// File: rtl/epass_reader.sv
`default_nettype none
// ============================================================================
// Module : epass_reader
// Brief  : Arms on entry sensor, collects a 5-byte tag frame, verifies the XOR
//          checksum and holds the tag ID until cleared. Option: EPASS_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
module epass_reader
    import epass_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int WIDTH_TO    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic        clear,
    input  logic        rx,
    output logic        valid_Epass,
    output logic [23:0] tag_id,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [WIDTH_TO-1:0] TO_LAST  = WIDTH_TO'(TIMEOUT_CYC - 1);
    localparam logic [1:0]          IDX_LAST = 2'(EPASS_FRAME_BYTES - 2);

    state_t                state_q, state_d;
    logic [WIDTH_TO-1:0]   to_cnt_q, to_cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           frame_q, frame_d;
    logic [23:0]           tag_q, tag_d;
    logic                  ferr_q, ferr_d;

    logic [7:0]            w_byte;
    logic                  w_byte_valid;
    logic                  w_byte_err;
    logic                  w_flush;
    logic                  w_timeout;
    logic                  w_chk_ok;

    assign w_flush   = arm && (state_q != ST_HOLD);
    assign w_timeout = (to_cnt_q == TO_LAST);
    assign w_chk_ok  = (frame_q[7:0] == (frame_q[31:24] ^ frame_q[23:16] ^ frame_q[15:8]));

    epass_byte_rx #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_i         (rx),
        .flush_i      (w_flush),
        .byte_o       (w_byte),
        .byte_valid_o (w_byte_valid),
        .byte_err_o   (w_byte_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            tag_q    <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            tag_q    <= tag_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        tag_d    = tag_q;
        ferr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    to_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                if (arm) begin
                    to_cnt_d = '0;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (w_byte_valid && (w_byte == EPASS_SOF)) begin
                        state_d = ST_COLLECT;
                        idx_d   = '0;
                    end
                end
            end
            ST_COLLECT: begin
                // Re-arming mid-frame drops everything collected so far.
                if (arm) begin
                    state_d  = ST_ARMED;
                    to_cnt_d = '0;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (w_byte_err) begin
                        state_d = ST_ARMED;
                        ferr_d  = 1'b1;
                    end else if (w_byte_valid) begin
                        frame_d = {frame_q[23:0], w_byte};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (w_chk_ok) begin
                    state_d = ST_HOLD;
                    tag_d   = frame_q[31:8];
                end else begin
                    state_d = ST_ARMED;
                    ferr_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign valid_Epass = (state_q == ST_HOLD);
    assign tag_id      = tag_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q == ST_ARMED) || (state_q == ST_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_epass_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_epass_reader
// Brief  : Self-checking bench for epass_reader with an event scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_epass_reader;
    import epass_pkg::*;

    localparam int CPB    = 16;
    localparam int K_VAL  = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [23:0] tag;
        int          lat;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic        rx = 1'b1;
    logic        valid_Epass, frame_err, busy;
    logic [23:0] tag_id;
    logic        to_valid, to_ferr, to_busy;
    logic [23:0] to_tag;

    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    int  obs_rd = 0;
    int  cyc = 0;
    int  last_strobe = -100;
    int  n_strobe = 0;
    int  n_err_strobe = 0;
    logic valid_prev = 1'b0;

    always #5 clk = ~clk;

    epass_reader #(.CLK_PER_BIT(CPB), .TIMEOUT_CYC(50000), .WIDTH_TO(16)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .rx(rx),
        .valid_Epass(valid_Epass), .tag_id(tag_id), .frame_err(frame_err), .busy(busy)
    );

    epass_reader #(.CLK_PER_BIT(CPB), .TIMEOUT_CYC(200), .WIDTH_TO(16)) dut_to (
        .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .rx(rx),
        .valid_Epass(to_valid), .tag_id(to_tag), .frame_err(to_ferr), .busy(to_busy)
    );

    // Observed output events of the main instance, logged away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        cyc = cyc + 1;
        if (dut.w_byte_valid) begin
            last_strobe = cyc;
            n_strobe = n_strobe + 1;
        end
        if (dut.w_byte_err) n_err_strobe = n_err_strobe + 1;
        if (valid_Epass && !valid_prev) begin
            e.kind = K_VAL; e.tag = tag_id; e.lat = cyc - last_strobe;
            obs_q.push_back(e);
        end
        if (frame_err) begin
            e.kind = K_ERR; e.tag = tag_id; e.lat = 0;
            obs_q.push_back(e);
        end
        valid_prev = valid_Epass;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; tick(CPB);
        end
`ifdef EPASS_PARITY_EN
        rx = ^b; tick(CPB);
`endif
        rx = 1'b1; tick(CPB);
    endtask

    task automatic send_frame(input logic [23:0] id, input logic [7:0] chk);
        send_byte(EPASS_SOF);
        send_byte(id[23:16]);
        send_byte(id[15:8]);
        send_byte(id[7:0]);
        send_byte(chk);
    endtask

    task automatic push_exp(input int kind, input logic [23:0] tag);
        ev_t e;
        e.kind = kind; e.tag = tag; e.lat = 2;
        exp_q.push_back(e);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(1); arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(1); clear = 1'b0;
    endtask

    // Fetch the next observed event within a cycle budget; no judgement here.
    task automatic next_obs(input int budget, output bit ok, output ev_t o);
        ok = 1'b0;
        o.kind = 0; o.tag = '0; o.lat = 0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() > obs_rd) break;
            @(negedge clk);
        end
        if (obs_q.size() > obs_rd) begin
            o = obs_q[obs_rd];
            obs_rd = obs_rd + 1;
            ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        @(negedge clk);
        total++; if (valid_Epass !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_Epass); end
        total++; if (tag_id !== 24'h0) begin bad++; $display("FAIL reset_tag got=%h want=000000", tag_id); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_good_frame();
        ev_t e, x; bit ok;
        pulse_arm();
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arm_busy got=%b want=1", busy); end
        @(posedge clk); #1;
        push_exp(K_VAL, 24'h123456);
        send_frame(24'h123456, 8'h70);
        next_obs(100, ok, e);
        x = exp_q.pop_front();
        total++;
        if (!ok) begin bad++; $display("FAIL good_event got=none want=valid"); end
        else begin
            if (e.kind !== x.kind || e.tag !== x.tag) begin bad++; $display("FAIL good_event got=kind%0d tag=%h want=kind%0d tag=%h", e.kind, e.tag, x.kind, x.tag); end
            total++; if (e.lat !== x.lat) begin bad++; $display("FAIL good_latency got=%0d want=%0d", e.lat, x.lat); end
        end
        @(negedge clk);
        total++; if (valid_Epass !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_levels got=valid%b busy%b want=valid1 busy0", valid_Epass, busy); end
        @(posedge clk); #1;
        pulse_clear();
        @(negedge clk);
        total++; if (valid_Epass !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b want=0", valid_Epass); end
        total++; if (tag_id !== 24'h123456) begin bad++; $display("FAIL clear_tag_keep got=%h want=123456", tag_id); end
        @(posedge clk); #1;
        total++; if (obs_q.size() !== obs_rd) begin bad++; $display("FAIL good_extra got=%0d want=0", obs_q.size() - obs_rd); end
    endtask

    task automatic test_bad_chk();
        ev_t e, x; bit ok;
        pulse_arm();
        push_exp(K_ERR, 24'h0);
        send_frame(24'h123456, 8'h71);
        next_obs(100, ok, e);
        x = exp_q.pop_front();
        total++; if (!ok || e.kind !== x.kind) begin bad++; $display("FAIL chk_err_event got=ok%0b kind%0d want=kind%0d", ok, e.kind, x.kind); end
        @(negedge clk);
        total++; if (valid_Epass !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL chk_err_levels got=valid%b busy%b want=valid0 busy1", valid_Epass, busy); end
        @(posedge clk); #1;
        push_exp(K_VAL, 24'hABCDEF);
        send_frame(24'hABCDEF, 8'h89);
        next_obs(100, ok, e);
        x = exp_q.pop_front();
        total++; if (!ok || e.kind !== x.kind || e.tag !== x.tag) begin bad++; $display("FAIL chk_recover got=ok%0b kind%0d tag=%h want=kind%0d tag=%h", ok, e.kind, e.tag, x.kind, x.tag); end
        pulse_clear();
        tick(2);
        total++; if (obs_q.size() !== obs_rd) begin bad++; $display("FAIL chk_extra got=%0d want=0", obs_q.size() - obs_rd); end
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        logic at200 = 1'b0, at201 = 1'b1, busy1 = 1'b0, busy201 = 1'b1;
        pulse_arm();
        for (int k = 1; k <= 201; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) busy1 = to_busy;
            if (k < 200 && to_ferr) early = 1'b1;
            if (k == 200) at200 = to_ferr;
            if (k == 201) begin at201 = to_ferr; busy201 = to_busy; end
        end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL to_busy_start got=%b want=1", busy1); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", early); end
        total++; if (at200 !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", at200); end
        total++; if (at201 !== 1'b0 || busy201 !== 1'b0) begin bad++; $display("FAIL to_after got=ferr%b busy%b want=ferr0 busy0", at201, busy201); end
        total++; if (dut_to.state_q !== ST_IDLE) begin bad++; $display("FAIL to_state got=%0d want=%0d", dut_to.state_q, ST_IDLE); end
        @(posedge clk); #1;
    endtask

    task automatic test_glitch();
        int s0 = n_strobe;
        int e0 = n_err_strobe;
        rx = 1'b0; tick(3);
        rx = 1'b1; tick(60);
        total++; if (n_strobe !== s0 || n_err_strobe !== e0) begin bad++; $display("FAIL glitch_byte got=bytes%0d errs%0d want=0 0", n_strobe - s0, n_err_strobe - e0); end
        total++; if (obs_q.size() !== obs_rd) begin bad++; $display("FAIL glitch_event got=%0d want=0", obs_q.size() - obs_rd); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b want=1", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_arm_clear_same();
        ev_t e, x; bit ok;
        pulse_arm();
        push_exp(K_VAL, 24'hC0FFEE);
        send_frame(24'hC0FFEE, 8'hD1);
        next_obs(100, ok, e);
        x = exp_q.pop_front();
        total++; if (!ok || e.kind !== x.kind || e.tag !== x.tag) begin bad++; $display("FAIL ac_frame got=ok%0b kind%0d tag=%h want=kind%0d tag=%h", ok, e.kind, e.tag, x.kind, x.tag); end
        arm = 1'b1; clear = 1'b1; tick(1); arm = 1'b0; clear = 1'b0;
        @(negedge clk);
        total++; if (valid_Epass !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ac_levels got=valid%b busy%b want=valid0 busy0", valid_Epass, busy); end
        total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL ac_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
        @(posedge clk); #1;
        tick(5);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ac_arm_dropped got=%b want=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        ev_t e, x; bit ok;
        pulse_arm();
        send_byte(EPASS_SOF);
        send_byte(8'h12);
        rx = 1'b0; tick(CPB);
        rx = 1'b1; tick(2 * CPB);
        #2 reset_n = 1'b0;
        #1;
        total++; if (valid_Epass !== 1'b0 || tag_id !== 24'h0 || frame_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid got=valid%b tag=%h ferr%b busy%b want=0 000000 0 0", valid_Epass, tag_id, frame_err, busy); end
        rx = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(200);
        total++; if (obs_q.size() !== obs_rd) begin bad++; $display("FAIL rst_mid_event got=%0d want=0", obs_q.size() - obs_rd); end
        pulse_arm();
        push_exp(K_VAL, 24'h5A5A5A);
        send_frame(24'h5A5A5A, 8'h5A);
        next_obs(100, ok, e);
        x = exp_q.pop_front();
        total++; if (!ok || e.kind !== x.kind || e.tag !== x.tag) begin bad++; $display("FAIL rst_recover got=ok%0b kind%0d tag=%h want=kind%0d tag=%h", ok, e.kind, e.tag, x.kind, x.tag); end
        pulse_clear();
        tick(2);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_timeout();
        test_glitch();
        test_arm_clear_same();
        test_reset_mid();
        total++; if (exp_q.size() !== 0 || obs_q.size() !== obs_rd) begin bad++; $display("FAIL final_queues got=exp%0d obs%0d want=0 0", exp_q.size(), obs_q.size() - obs_rd); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
